// File: rtl/hazard_scoreboard.sv
// Load-use hazard scoreboard for an in-order pipeline: tracks destination registers of
// in-flight stages, selects the youngest forwarding source and stalls ID on load-use.
module hazard_scoreboard #(
  parameter  int REG_ADDR_W = 5,
  parameter  int FWD_STAGES = 3,
  parameter  int LOAD_LAT   = 1,
  parameter  int CNT_W      = 16,
  localparam int SEL_W      = $clog2(FWD_STAGES + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_id_valid,
  input  logic [REG_ADDR_W-1:0] i_id_rs1,
  input  logic [REG_ADDR_W-1:0] i_id_rs2,
  input  logic                  i_id_use_rs1,
  input  logic                  i_id_use_rs2,
  input  logic [REG_ADDR_W-1:0] i_id_rd,
  input  logic                  i_id_rf_we,
  input  logic                  i_id_is_load,
  input  logic                  i_flush,
  input  logic                  i_cnt_clr,
  output logic [SEL_W-1:0]      o_fwd_sel_a,
  output logic [SEL_W-1:0]      o_fwd_sel_b,
  output logic                  o_stall,
  output logic                  o_issue,
  output logic [CNT_W-1:0]      o_stall_cnt
);

  logic [FWD_STAGES:1]   r_valid;
  logic [FWD_STAGES:1]   r_we;
  logic [FWD_STAGES:1]   r_load;
  logic [REG_ADDR_W-1:0] r_rd [1:FWD_STAGES];
  logic [CNT_W-1:0]      r_stall_cnt;

  logic [FWD_STAGES:1]   w_match_a;
  logic [FWD_STAGES:1]   w_match_b;
  logic [SEL_W-1:0]      w_sel_a;
  logic [SEL_W-1:0]      w_sel_b;
  logic                  w_haz_a;
  logic                  w_haz_b;
  logic                  w_stall;
  logic                  w_issue;

  // x0 is hardwired zero, so it never matches a producer.
  for (genvar gi = 1; gi <= FWD_STAGES; gi++) begin : g_match
    assign w_match_a[gi] = i_id_use_rs1 && r_valid[gi] && r_we[gi] &&
                           (r_rd[gi] == i_id_rs1) && (i_id_rs1 != '0);
    assign w_match_b[gi] = i_id_use_rs2 && r_valid[gi] && r_we[gi] &&
                           (r_rd[gi] == i_id_rs2) && (i_id_rs2 != '0);
  end

  // Scan oldest to youngest so the youngest match wins.
  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    w_haz_a = 1'b0;
    w_haz_b = 1'b0;
    for (int k = FWD_STAGES; k >= 1; k--) begin
      if (w_match_a[k]) begin
        w_sel_a = SEL_W'(k);
        w_haz_a = r_load[k] && (k <= LOAD_LAT);
      end
      if (w_match_b[k]) begin
        w_sel_b = SEL_W'(k);
        w_haz_b = r_load[k] && (k <= LOAD_LAT);
      end
    end
  end

  assign w_stall = i_rst_n & i_id_valid & (w_haz_a | w_haz_b) & ~i_flush;
  assign w_issue = i_rst_n & i_id_valid & ~w_stall & ~i_flush;

  // Stage 1 takes the issuing instruction or a bubble (stall or flush).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid[1] <= 1'b0;
      r_we[1]    <= 1'b0;
      r_load[1]  <= 1'b0;
      r_rd[1]    <= '0;
    end else begin
      r_valid[1] <= w_issue;
      r_we[1]    <= w_issue & i_id_rf_we;
      r_load[1]  <= w_issue & i_id_is_load;
      r_rd[1]    <= w_issue ? i_id_rd : '0;
    end
  end

  for (genvar gi = 2; gi <= FWD_STAGES; gi++) begin : g_shift
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_valid[gi] <= 1'b0;
        r_we[gi]    <= 1'b0;
        r_load[gi]  <= 1'b0;
        r_rd[gi]    <= '0;
      end else begin
        r_valid[gi] <= r_valid[gi-1];
        r_we[gi]    <= r_we[gi-1];
        r_load[gi]  <= r_load[gi-1];
        r_rd[gi]    <= r_rd[gi-1];
      end
    end
  end

  // Clear beats increment; count saturates at all-ones.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cnt <= '0;
    end else if (i_cnt_clr) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign o_fwd_sel_a = w_sel_a;
  assign o_fwd_sel_b = w_sel_b;
  assign o_stall     = w_stall;
  assign o_issue     = w_issue;
  assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed vector table, counter and reset
// sequences, and randomized traffic against a queue-based pipeline model.
module tb_hazard_scoreboard;

  localparam int RW = 5;
  localparam int NS = 3;
  localparam int LL = 1;
  localparam int CW = 4;
  localparam int SW = $clog2(NS + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          id_valid, id_use_rs1, id_use_rs2, id_rf_we, id_is_load, flush, cnt_clr;
  logic [RW-1:0] id_rs1, id_rs2, id_rd;
  logic [SW-1:0] fwd_sel_a, fwd_sel_b;
  logic          stall, issue;
  logic [CW-1:0] stall_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(
    .REG_ADDR_W(RW), .FWD_STAGES(NS), .LOAD_LAT(LL), .CNT_W(CW)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_id_valid(id_valid),
    .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
    .i_id_use_rs1(id_use_rs1), .i_id_use_rs2(id_use_rs2),
    .i_id_rd(id_rd), .i_id_rf_we(id_rf_we), .i_id_is_load(id_is_load),
    .i_flush(flush), .i_cnt_clr(cnt_clr),
    .o_fwd_sel_a(fwd_sel_a), .o_fwd_sel_b(fwd_sel_b),
    .o_stall(stall), .o_issue(issue), .o_stall_cnt(stall_cnt)
  );

  // Reference model: queue of in-flight instructions, index 0 = youngest (stage 1).
  typedef struct {
    bit valid;
    int rd;
    bit we;
    bit load;
  } ent_t;

  ent_t pipe[$];
  int   m_cnt;

  function automatic int youngest(int s, bit used);
    if (!used || s == 0) return 0;
    for (int i = 0; i < pipe.size(); i++)
      if (pipe[i].valid && pipe[i].we && pipe[i].rd == s) return i + 1;
    return 0;
  endfunction

  function automatic bit load_hazard(int s, bit used);
    int k = youngest(s, used);
    return (k != 0) && pipe[k-1].load && (k <= LL);
  endfunction

  function automatic bit m_stall();
    return id_valid && (load_hazard(int'(id_rs1), id_use_rs1) ||
                        load_hazard(int'(id_rs2), id_use_rs2)) && !flush;
  endfunction

  function automatic bit m_issue();
    return id_valid && !m_stall() && !flush;
  endfunction

  task automatic m_reset();
    ent_t b;
    b.valid = 0; b.rd = 0; b.we = 0; b.load = 0;
    pipe.delete();
    for (int i = 0; i < NS; i++) pipe.push_back(b);
    m_cnt = 0;
  endtask

  task automatic m_tick();
    bit   st = m_stall();
    bit   is = m_issue();
    ent_t e;
    e.valid = is; e.rd = int'(id_rd); e.we = id_rf_we; e.load = id_is_load;
    pipe.push_front(e);
    void'(pipe.pop_back());
    if (cnt_clr) m_cnt = 0;
    else if (st && m_cnt < (1 << CW) - 1) m_cnt++;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_sel_a"}, int'(fwd_sel_a), youngest(int'(id_rs1), id_use_rs1));
    chk({tag, "_sel_b"}, int'(fwd_sel_b), youngest(int'(id_rs2), id_use_rs2));
    chk({tag, "_stall"}, int'(stall), int'(m_stall()));
    chk({tag, "_issue"}, int'(issue), int'(m_issue()));
    chk({tag, "_cnt"}, int'(stall_cnt), m_cnt);
  endtask

  task automatic drive(input logic v, input int rs1, input int rs2, input logic u1,
                       input logic u2, input int rd, input logic we, input logic ld,
                       input logic fl, input logic clr);
    id_valid = v; id_rs1 = RW'(rs1); id_rs2 = RW'(rs2);
    id_use_rs1 = u1; id_use_rs2 = u2; id_rd = RW'(rd);
    id_rf_we = we; id_is_load = ld; flush = fl; cnt_clr = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) m_tick();
    @(negedge clk);
  endtask

  typedef struct {
    logic v;
    int   rs1, rs2;
    logic u1, u2;
    int   rd;
    logic we, ld, fl, clr;
    int   sa, sb, st, is, cnt;
  } vec_t;

  vec_t tbl[19];

  initial begin
    // v rs1 rs2 u1 u2 rd we ld fl clr | sel_a sel_b stall issue cnt
    tbl[0]  = '{1, 0, 0, 0, 0, 5, 1, 0, 0, 0,  0, 0, 0, 1, 0};  // add x5
    tbl[1]  = '{1, 5, 0, 1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 1, 0};
    tbl[2]  = '{1, 5, 0, 1, 0, 0, 0, 0, 0, 0,  2, 0, 0, 1, 0};
    tbl[3]  = '{1, 5, 0, 1, 0, 0, 0, 0, 0, 0,  3, 0, 0, 1, 0};
    tbl[4]  = '{1, 5, 0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0};
    tbl[5]  = '{1, 0, 0, 0, 0, 7, 1, 1, 0, 0,  0, 0, 0, 1, 0};  // lw x7
    tbl[6]  = '{1, 0, 7, 0, 1, 8, 1, 0, 0, 0,  0, 1, 1, 0, 0};  // load-use stall
    tbl[7]  = '{1, 0, 7, 0, 1, 8, 1, 0, 0, 0,  0, 2, 0, 1, 1};
    tbl[8]  = '{1, 0, 0, 0, 0, 3, 1, 0, 0, 0,  0, 0, 0, 1, 1};  // x3 producer
    tbl[9]  = '{1, 0, 0, 0, 0, 3, 1, 0, 0, 0,  0, 0, 0, 1, 1};  // x3 producer again
    tbl[10] = '{1, 3, 3, 1, 1, 0, 1, 1, 0, 0,  1, 1, 0, 1, 1};  // youngest x3; load to x0
    tbl[11] = '{1, 0, 3, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1};  // x0 and unused rs2
    tbl[12] = '{1, 0, 0, 0, 0, 9, 1, 1, 0, 0,  0, 0, 0, 1, 1};  // lw x9
    tbl[13] = '{1, 9, 0, 1, 0, 10, 1, 0, 1, 0, 1, 0, 0, 0, 1};  // flush beats stall
    tbl[14] = '{1, 10, 9, 1, 1, 0, 0, 0, 0, 0, 0, 2, 0, 1, 1};  // killed x10 absent
    tbl[15] = '{1, 0, 0, 0, 0, 4, 1, 1, 0, 0,  0, 0, 0, 1, 1};  // lw x4
    tbl[16] = '{0, 4, 0, 1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 1};  // invalid ID never stalls
    tbl[17] = '{1, 4, 0, 1, 0, 0, 0, 0, 0, 1,  2, 0, 0, 1, 1};  // load past window; clear
    tbl[18] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0};

    // Reset held low with a valid ID instruction present.
    drive(1, 1, 2, 1, 1, 3, 1, 1, 0, 0);
    m_reset();
    #1;
    chk("reset_sel_a", int'(fwd_sel_a), 0);
    chk("reset_sel_b", int'(fwd_sel_b), 0);
    chk("reset_stall", int'(stall), 0);
    chk("reset_issue", int'(issue), 0);
    chk("reset_cnt", int'(stall_cnt), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].v, tbl[i].rs1, tbl[i].rs2, tbl[i].u1, tbl[i].u2, tbl[i].rd,
            tbl[i].we, tbl[i].ld, tbl[i].fl, tbl[i].clr);
      #1;
      chk($sformatf("row%0d_sel_a", i), int'(fwd_sel_a), tbl[i].sa);
      chk($sformatf("row%0d_sel_b", i), int'(fwd_sel_b), tbl[i].sb);
      chk($sformatf("row%0d_stall", i), int'(stall), tbl[i].st);
      chk($sformatf("row%0d_issue", i), int'(issue), tbl[i].is);
      chk($sformatf("row%0d_cnt", i), int'(stall_cnt), tbl[i].cnt);
      tick();
    end

    // Back-to-back "lw x7, (x7)" stalls every other cycle: more than 2^CW+3 stalls.
    drive(1, 7, 0, 1, 0, 7, 1, 1, 0, 0);
    for (int i = 0; i < 44; i++) begin
      #1;
      check_model($sformatf("sat%0d", i));
      tick();
    end
    chk("cnt_saturated", int'(stall_cnt), (1 << CW) - 1);

    // Clear asserted in a stall cycle wins over the increment.
    begin
      bit found = 0;
      for (int i = 0; i < 4 && !found; i++) begin
        #1;
        if (m_stall()) found = 1;
        else tick();
      end
      chk("clr_stall_found", int'(found), 1);
      cnt_clr = 1'b1;
      #1;
      chk("clr_stall_active", int'(stall), 1);
      tick();
      cnt_clr = 1'b0;
      #1;
      chk("cnt_clr_over_stall", int'(stall_cnt), 0);
      tick();
    end

    // Randomized traffic on a small register range to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 7) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3),
            $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
      #1;
      check_model($sformatf("rand%0d", i));
      tick();
    end

    // Reset between edges with three valid entries in flight.
    drive(1, 0, 0, 0, 0, 11, 1, 0, 0, 0); #1; check_model("mid_p11"); tick();
    drive(1, 0, 0, 0, 0, 12, 1, 0, 0, 0); #1; check_model("mid_p12"); tick();
    drive(1, 0, 0, 0, 0, 13, 1, 0, 0, 0); #1; check_model("mid_p13"); tick();
    drive(1, 11, 13, 1, 1, 0, 0, 0, 0, 0);
    #1;
    check_model("mid_pre");
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    chk("mid_rst_sel_a", int'(fwd_sel_a), 0);
    chk("mid_rst_sel_b", int'(fwd_sel_b), 0);
    chk("mid_rst_stall", int'(stall), 0);
    chk("mid_rst_issue", int'(issue), 0);
    chk("mid_rst_cnt", int'(stall_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 13, 12, 1, 1, 0, 0, 0, 0, 0);
    #1;
    chk("post_rst_sel_a", int'(fwd_sel_a), 0);
    chk("post_rst_sel_b", int'(fwd_sel_b), 0);
    check_model("post_rst");
    tick();
    drive(1, 12, 11, 1, 1, 0, 0, 0, 0, 0);
    #1;
    chk("post_rst2_sel_a", int'(fwd_sel_a), 0);
    check_model("post_rst2");
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter REG_ADDR_W, default 5, register-address width.
REQ-002 Parameter FWD_STAGES, default 3, number of tracked stages downstream of ID (stage 1 = EX, 2 = MEM, 3 = WB); legal range 1..7.
REQ-003 Parameter LOAD_LAT, default 1, number of stages (1..FWD_STAGES) in which a load result is still unavailable for forwarding.
REQ-004 Parameter CNT_W, default 16, stall-counter width.
REQ-005 Localparam SEL_W = clog2(FWD_STAGES+1).
REQ-006 clk  input  1  single clock; all state updates on the rising edge.
REQ-007 Reset  input  1  asynchronous, active-low reset.
REQ-008 id_valid  input  1  ID holds a valid instruction.
REQ-009 id_rs1, id_rs2  input  REG_ADDR_W  ID source registers.
REQ-010 id_use_rs1, id_use_rs2  input  1  ID instruction reads the corresponding source.
REQ-011 id_rd  input  REG_ADDR_W  ID destination register.
REQ-012 id_rf_we  input  1  ID instruction writes the register file.
REQ-013 id_is_load  input  1  ID instruction is a load.
REQ-014 flush  input  1  taken branch or jump resolved in EX; kills the ID instruction.
REQ-015 cnt_clr  input  1  synchronous clear of stall_cnt.
REQ-016 fwd_sel_a, fwd_sel_b  output  SEL_W  operand source: 0 = register file, k = stage-k result.
REQ-017 stall  output  1  hold PC and IF/ID, and insert a bubble into EX.
REQ-018 issue  output  1  ID instruction enters stage 1 at this edge.
REQ-019 stall_cnt  output  CNT_W  count of stall cycles.

Function
REQ-020 The block keeps FWD_STAGES tracking entries {valid, rd, we, load}; entry k mirrors pipeline stage k.
REQ-021 At each edge, entry k (k>1) loads entry k-1; entry 1 loads {1, id_rd, id_rf_we, id_is_load} when issue=1, otherwise a bubble (valid=0).
REQ-022 Entry k matches source s when valid=1, we=1, rd==s, and s!=0.
REQ-023 For each used source, fwd_sel is the smallest matching k (youngest producer); if there is no match, or the source is unused, fwd_sel is 0.
REQ-024 A load hazard exists when the youngest match for a used source is an entry with load=1 and k<=LOAD_LAT.
REQ-025 stall = id_valid & load hazard & ~flush; stall is combinational from the current entries and ID inputs.
REQ-026 issue = id_valid & ~stall & ~flush.
REQ-027 When stall=1, fwd_sel outputs still reflect the youngest match; consumers ignore them because a bubble is inserted.
REQ-028 flush has priority over stall: stall=0, issue=0, and entry 1 receives a bubble; entries k>1 shift normally.
REQ-029 A killed instruction never appears as a forwarding source in any later cycle.
REQ-030 stall_cnt increments by 1 on each edge with stall=1 and saturates at all-ones.
REQ-031 cnt_clr=1 sets stall_cnt to 0 at the edge, overriding a simultaneous increment.
REQ-032 The block needs no extra cycle when LOAD_LAT=FWD_STAGES; a load then stalls until it leaves the tracked window and fwd_sel is 0.

Reset
REQ-033 Reset low immediately clears all entries and sets stall_cnt to 0, regardless of clk.
REQ-034 While Reset is low: fwd_sel_a=0, fwd_sel_b=0, stall=0, issue=0.
REQ-035 Reset asserted mid-operation discards all in-flight tracking.
REQ-036 After Reset is released, the first edge behaves as from an empty pipeline.

Verification (FWD_STAGES=3, LOAD_LAT=1)
REQ-037 Distance forwarding: issue "add x5", then ID consumers reading x5 in rs1 on the next four cycles -> fwd_sel_a = 1, 2, 3, 0 in successive cycles; stall=0 throughout.
REQ-038 Load-use: issue "lw x7", next ID instruction reads x7 via rs2 -> stall=1 and issue=0 for one cycle, then fwd_sel_b=2, issue=1, and stall_cnt=1.
REQ-039 Youngest producer and x0:
  - x3 written in both EX and MEM -> fwd_sel=1.
  - Producer rd=x0, consumer rs1=x0 -> fwd_sel_a=0, stall=0.
REQ-040 Flush: load-use condition together with flush=1 -> stall=0, issue=0; the next cycle shows no match against the killed rd; stall_cnt is unchanged.
REQ-041 Counter:
  - Force 2^CNT_W+3 stall cycles -> stall_cnt holds at all-ones.
  - cnt_clr asserted with stall=1 -> stall_cnt=0.
REQ-042 Reset mid-stream: with three valid entries, drive Reset low between edges -> all outputs 0 asynchronously; after release, a consumer of the prior rd gets fwd_sel=0.
